// File: rtl/mux2to1_trio.sv
// ---------------------------------------------------------------------------
// mux2to1_trio
//
// Purpose:
//   2:1 word select computed three independent ways (conditional operator,
//   if/else, case). All three must agree. The conditional-operator result is
//   also registered, and a small checker flags, remembers and counts any
//   disagreement between the three combinational results.
//
// Ports:
//   clk              rising-edge clock for all registered state
//   rst_n            asynchronous active-low reset
//   in0              data selected when sel = 0
//   in1              data selected when sel = 1
//   sel              select
//   out1             combinational result, conditional-operator form
//   out2             combinational result, if/else form
//   out3             combinational result, case form (default picks in0)
//   out_q            out1 registered, one cycle of latency
//   mismatch         combinational, 1 when out1/out2/out3 are not all equal
//   mismatch_sticky  set on any edge where mismatch = 1, cleared by reset only
//   err_cnt          saturating count of edges where mismatch = 1
//
// Interface timing: no handshake. Combinational outputs follow the inputs in
// the same time step; registered outputs update on the rising clock edge and
// are forced to zero immediately while rst_n is low.
// ---------------------------------------------------------------------------
module mux2to1_trio #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out_q,
  output logic             mismatch,
  output logic             mismatch_sticky,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Registered state and next-state values.
  logic [WIDTH-1:0] out_q_q,    out_q_d;
  logic             sticky_q,   sticky_d;
  logic [CNT_W-1:0] err_cnt_q,  err_cnt_d;

  // ---------------------------------------------------------------------
  // Three independent mux implementations; none shares an expression with
  // another, so a coding error in one shows up as a disagreement.
  // ---------------------------------------------------------------------
  assign out1 = sel ? in1 : in0;

  always_comb begin
    if (sel) begin
      out2 = in1;
    end else begin
      out2 = in0;
    end
  end

  always_comb begin
    out3 = in0;
    case (sel)
      1'b0:    out3 = in0;
      1'b1:    out3 = in1;
      default: out3 = in0;
    endcase
  end

  // Any pairwise difference means the three results are not all equal.
  assign mismatch = (out1 != out2) || (out1 != out3);

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    out_q_d   = out1;
    sticky_d  = sticky_q | mismatch;
    err_cnt_d = err_cnt_q;
    // Saturate rather than wrap so a long-running fault is never hidden.
    if (mismatch && (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q_q   <= '0;
      sticky_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      out_q_q   <= out_q_d;
      sticky_q  <= sticky_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_q           = out_q_q;
  assign mismatch_sticky = sticky_q;
  assign err_cnt         = err_cnt_q;

endmodule

// File: tb/tb_mux2to1_trio.sv
// ---------------------------------------------------------------------------
// tb_mux2to1_trio
//
// Two instances: u1 (WIDTH=1, CNT_W=2) for the truth table, async reset and
// counter saturation; u8 (WIDTH=8, CNT_W=8) for wide data, output lag and
// the mismatch checker. A behavioural model tracks the expected registered
// state; a compare process checks every output each cycle, and directed
// steps add literal expectations.
// ---------------------------------------------------------------------------
module tb_mux2to1_trio;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #10 clk = ~clk;
  logic rst_n;

  // ---------------- u1 signals ----------------
  logic       sel_1;
  logic [0:0] in0_1, in1_1, out1_1, out2_1, out3_1, out_q_1;
  logic       mm_1, st_1;
  logic [1:0] cnt_1;

  // ---------------- u8 signals ----------------
  logic       sel_8;
  logic [7:0] in0_8, in1_8, out1_8, out2_8, out3_8, out_q_8;
  logic       mm_8, st_8;
  logic [7:0] cnt_8;

  mux2to1_trio #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in0(in0_1), .in1(in1_1), .sel(sel_1),
    .out1(out1_1), .out2(out2_1), .out3(out3_1), .out_q(out_q_1),
    .mismatch(mm_1), .mismatch_sticky(st_1), .err_cnt(cnt_1)
  );

  mux2to1_trio #(.WIDTH(8), .CNT_W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in0(in0_8), .in1(in1_8), .sel(sel_8),
    .out1(out1_8), .out2(out2_8), .out3(out3_8), .out_q(out_q_8),
    .mismatch(mm_8), .mismatch_sticky(st_8), .err_cnt(cnt_8)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int passed = 0;
  bit chk_en = 1'b0;

  // Fault flags: set while the bench forces out2 of an instance to zero.
  bit fault_1 = 1'b0;
  bit fault_8 = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m8_q   = '0;
  bit         m8_st  = 1'b0;
  int         m8_cnt = 0;
  logic [0:0] m1_q   = '0;
  bit         m1_st  = 1'b0;
  int         m1_cnt = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m8_q <= '0; m8_st <= 1'b0; m8_cnt <= 0;
      m1_q <= '0; m1_st <= 1'b0; m1_cnt <= 0;
    end else begin
      m8_q <= sel_8 ? in1_8 : in0_8;
      m1_q <= sel_1 ? in1_1 : in0_1;
      if (fault_8) begin
        m8_st <= 1'b1;
        if (m8_cnt < 255) m8_cnt <= m8_cnt + 1;
      end
      if (fault_1) begin
        m1_st <= 1'b1;
        if (m1_cnt < 3) m1_cnt <= m1_cnt + 1;
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    logic [7:0] e8;
    logic [0:0] e1;
    if (chk_en) begin
      #2;
      e8 = sel_8 ? in1_8 : in0_8;
      e1 = sel_1 ? in1_1 : in0_1;
      chk("u8.out1",   32'(out1_8),  32'(e8));
      chk("u8.out2",   32'(out2_8),  32'(fault_8 ? 8'h00 : e8));
      chk("u8.out3",   32'(out3_8),  32'(e8));
      chk("u8.mismatch", 32'(mm_8),  32'(fault_8));
      chk("u8.out_q",  32'(out_q_8), 32'(m8_q));
      chk("u8.sticky", 32'(st_8),    32'(m8_st));
      chk("u8.err_cnt", 32'(cnt_8),  32'(m8_cnt));
      chk("u1.out1",   32'(out1_1),  32'(e1));
      chk("u1.out2",   32'(out2_1),  32'(fault_1 ? 1'b0 : e1));
      chk("u1.out3",   32'(out3_1),  32'(e1));
      chk("u1.mismatch", 32'(mm_1),  32'(fault_1));
      chk("u1.out_q",  32'(out_q_1), 32'(m1_q));
      chk("u1.sticky", 32'(st_1),    32'(m1_st));
      chk("u1.err_cnt", 32'(cnt_1),  32'(m1_cnt));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d passed=%0d", checks, passed);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  logic [7:0] tt_exp = 8'hCA;  // bit v = expected out for {sel,in1,in0} = v
  logic [7:0] prev8;

  initial begin
    rst_n = 1'b0;
    sel_1 = 1'b0; in0_1 = '0; in1_1 = '0;
    sel_8 = 1'b0; in0_8 = '0; in1_8 = '0;
    prev8 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst.u8.out_q",  32'(out_q_8), 32'h0);
    chk("rst.u8.sticky", 32'(st_8),    32'h0);
    chk("rst.u8.err_cnt", 32'(cnt_8),  32'h0);
    chk("rst.u1.out_q",  32'(out_q_1), 32'h0);
    chk("rst.u1.err_cnt", 32'(cnt_1),  32'h0);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Exhaustive truth table on u1
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      {sel_1, in1_1, in0_1} = 3'(v);
      #1;
      chk($sformatf("tt%0d.out1", v), 32'(out1_1), 32'(tt_exp[v]));
      chk($sformatf("tt%0d.out2", v), 32'(out2_1), 32'(tt_exp[v]));
      chk($sformatf("tt%0d.out3", v), 32'(out3_1), 32'(tt_exp[v]));
      chk($sformatf("tt%0d.mismatch", v), 32'(mm_1), 32'h0);
    end

    // Wide data on u8
    @(negedge clk);
    in0_8 = 8'hA5; in1_8 = 8'h3C; sel_8 = 1'b0;
    #1;
    chk("wide.sel0.out1", 32'(out1_8), 32'hA5);
    chk("wide.sel0.out2", 32'(out2_8), 32'hA5);
    chk("wide.sel0.out3", 32'(out3_8), 32'hA5);
    @(negedge clk);
    sel_8 = 1'b1;
    #1;
    chk("wide.sel1.out1", 32'(out1_8), 32'h3C);
    chk("wide.sel1.out2", 32'(out2_8), 32'h3C);
    chk("wide.sel1.out3", 32'(out3_8), 32'h3C);

    // Toggle sel every cycle: out_q must equal the previous cycle's out1
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) chk($sformatf("lag%0d", i), 32'(out_q_8), 32'(prev8));
      sel_8 = ~sel_8;
      prev8 = sel_8 ? 8'h3C : 8'hA5;
    end

    // Async reset on u1 with out_q = 1
    @(negedge clk);
    {sel_1, in1_1, in0_1} = 3'b001;
    @(negedge clk);
    #1;
    chk("arst.pre.out_q", 32'(out_q_1), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_q",   32'(out_q_1), 32'h0);
    chk("arst.sticky",  32'(st_1),    32'h0);
    chk("arst.err_cnt", 32'(cnt_1),   32'h0);
    in0_1 = 1'b0;
    #1;
    chk("arst.track0", 32'(out1_1), 32'h0);
    in0_1 = 1'b1;
    #1;
    chk("arst.track1", 32'(out3_1), 32'h1);
    rst_n = 1'b1;
    #1;
    chk("arst.hold_till_edge", 32'(out_q_1), 32'h0);
    @(negedge clk);
    #1;
    chk("arst.reload", 32'(out_q_1), 32'h1);

    // Checker: forced fault on u8 out2 for three edges
    @(negedge clk);
    in0_8 = 8'hA5; sel_8 = 1'b0;
    fault_8 = 1'b1;
    force u8.out2 = 8'h00;
    #1;
    chk("fault.mismatch", 32'(mm_8), 32'h1);
    chk("fault.sticky_before_edge", 32'(st_8), 32'h0);
    @(negedge clk);
    #1;
    chk("fault.sticky_edge1", 32'(st_8),  32'h1);
    chk("fault.cnt_edge1",    32'(cnt_8), 32'h1);
    repeat (2) @(negedge clk);
    #1;
    chk("fault.cnt_edge3", 32'(cnt_8), 32'h3);
    release u8.out2;
    fault_8 = 1'b0;
    in0_8 = 8'h5A;
    #1;
    chk("fault.cleared", 32'(mm_8), 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("fault.sticky_holds", 32'(st_8),  32'h1);
    chk("fault.cnt_holds",    32'(cnt_8), 32'h3);

    // Saturation on u1 (CNT_W = 2): five mismatch edges
    @(negedge clk);
    {sel_1, in1_1, in0_1} = 3'b001;
    fault_1 = 1'b1;
    force u1.out2 = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("sat.cnt", 32'(cnt_1), 32'h3);
    release u1.out2;
    fault_1 = 1'b0;
    in0_1 = 1'b0;
    #1;
    chk("sat.cleared", 32'(mm_1), 32'h0);
    @(negedge clk);
    #1;
    chk("sat.cnt_holds", 32'(cnt_1), 32'h3);

    // Reset during a sustained mismatch on u8
    #2;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    in0_8 = 8'hA5; sel_8 = 1'b0;
    fault_8 = 1'b1;
    force u8.out2 = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rstmm.cnt2", 32'(cnt_8), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rstmm.cnt_cleared",    32'(cnt_8), 32'h0);
    chk("rstmm.sticky_cleared", 32'(st_8),  32'h0);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rstmm.cnt_resume", 32'(cnt_8), 32'h1);
    chk("rstmm.sticky_set", 32'(st_8),  32'h1);
    release u8.out2;
    fault_8 = 1'b0;
    in0_8 = 8'h96;
    @(negedge clk);
    #1;
    chk("rstmm.cnt_hold", 32'(cnt_8), 32'h1);

    repeat (2) @(negedge clk);
    #4;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/mux2to1_trio.md
Name: mux2to1_trio

Overview:
- Selects between two data words and produces the result three ways: conditional operator, if/else, and case. All three must agree.
- Registers the selected value and watches the three results for disagreement.
- Used as a 2:1 select primitive and as a self-checking reference for mux coding styles in the logic-design practice datapath.

Parameters:
- WIDTH, 1, bit width of in0, in1, out1, out2, out3 and out_q.
- CNT_W, 8, width of the saturating mismatch counter err_cnt.

Ports:
- clk  input  1  rising-edge clock for all registered state.
- rst_n  input  1  asynchronous active-low reset.
- in0  input  WIDTH  data selected when sel=0.
- in1  input  WIDTH  data selected when sel=1.
- sel  input  1  select.
- out1  output  WIDTH  combinational mux result, conditional-operator implementation.
- out2  output  WIDTH  combinational mux result, if/else implementation.
- out3  output  WIDTH  combinational mux result, case implementation (default branch selects in0).
- out_q  output  WIDTH  registered copy of out1.
- mismatch  output  1  combinational; 1 when out1, out2 and out3 are not all equal.
- mismatch_sticky  output  1  registered; set on any clock edge where mismatch=1, cleared only by reset.
- err_cnt  output  CNT_W  registered count of clock edges with mismatch=1.

Behaviour:
- Combinational path: out1 = out2 = out3 = (sel ? in1 : in0), bitwise across WIDTH.
  - No clock involvement and zero latency; outputs follow inputs within the same delta/time step.
  - Each output must come from its own independent implementation. No sharing of one expression among the three.
- Truth table for WIDTH=1, with {sel,in1,in0} giving out:
  - 000->0, 001->1, 010->0, 011->1, 100->0, 101->0, 110->1, 111->1.
- Defined behaviour covers sel = 0 or 1 only. Driving sel X/Z is illegal; outputs are unspecified in that case and mismatch may assert.
- Registered path:
  - On posedge clk with rst_n=1, out_q <= out1 (latency 1 cycle).
  - mismatch_sticky <= mismatch_sticky | mismatch.
  - err_cnt <= err_cnt + 1 when mismatch=1 and err_cnt < all-ones; otherwise it holds. The counter saturates at 2^CNT_W-1 and never wraps.
- Reset:
  - rst_n=0 immediately (asynchronously) forces out_q=0, mismatch_sticky=0, err_cnt=0, independent of clk.
  - Combinational outputs out1/out2/out3/mismatch are unaffected by reset.
  - Deassertion is taken on the next rising clk edge. Reset asserted mid-stream discards the held out_q value and all error history.
- Simultaneous events: an input change at a clock edge is sampled with normal setup semantics. out_q reflects the value present before the edge.
- With a correct implementation, mismatch stays 0 and err_cnt stays 0 for all legal inputs.

Test Plan:
- Exhaustive truth table (WIDTH=1): apply {sel,in1,in0}=000..111, 50 time units apart, and display after settling -> out1=out2=out3 = 0,1,0,1,0,0,1,1 respectively; mismatch=0 throughout.
- Wide data (WIDTH=8): in0=8'hA5, in1=8'h3C; sel=0 -> all outs 8'hA5; sel=1 -> all outs 8'h3C; toggle sel each cycle -> out_q lags out1 by exactly one clk.
- Async reset: with out_q=1, drive rst_n=0 between clock edges -> out_q, mismatch_sticky and err_cnt go to 0 immediately; out1..out3 continue to track inputs. Release rst_n -> out_q loads on the next posedge.
- Checker (forced fault on out2 in the bench model, or checker exercised via a bind/force): hold a mismatch for 3 edges -> mismatch=1, mismatch_sticky=1 after the first edge, err_cnt=3. Remove the fault -> sticky stays 1 and err_cnt holds at 3.
- Saturation (CNT_W=2): hold a mismatch for 5 edges -> err_cnt reaches 3 and stays at 3.
- Reset during a sustained mismatch: err_cnt=2 with rst_n pulsed low -> err_cnt=0 and sticky=0, then counting resumes from 1 on the first edge after release.
